// File: rtl/drive_pkg.sv
// Shared types and constants for the motor drive arbiter: FSM states, command
// bit layout and the legality filter applied to a granted command.
package drive_pkg;

  localparam int unsigned NREQ      = 3;
  localparam int unsigned CMD_W     = 8;
  localparam int unsigned DUTY_W    = 2;

  localparam int unsigned FWD_A_BIT = 7;
  localparam int unsigned FWD_B_BIT = 6;
  localparam int unsigned BWD_A_BIT = 5;
  localparam int unsigned BWD_B_BIT = 4;
  localparam int unsigned DUTY_A_HI = 3;
  localparam int unsigned DUTY_A_LO = 2;
  localparam int unsigned DUTY_B_HI = 1;
  localparam int unsigned DUTY_B_LO = 0;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DEAD   = 2'd1,
    ACTIVE = 2'd2
  } state_t;

  typedef struct packed {
    logic              fwd_a;
    logic              fwd_b;
    logic              bwd_a;
    logic              bwd_b;
    logic [DUTY_W-1:0] duty_a;
    logic [DUTY_W-1:0] duty_b;
    logic              fault;
  } motor_t;

  // A side commanding both directions at once is shorted out entirely; the other side passes.
  function automatic motor_t cmd_filter(input logic [CMD_W-1:0] cmd);
    motor_t m;
    logic   bad_a;
    logic   bad_b;
    bad_a    = cmd[FWD_A_BIT] & cmd[BWD_A_BIT];
    bad_b    = cmd[FWD_B_BIT] & cmd[BWD_B_BIT];
    m.fwd_a  = cmd[FWD_A_BIT] & ~bad_a;
    m.bwd_a  = cmd[BWD_A_BIT] & ~bad_a;
    m.fwd_b  = cmd[FWD_B_BIT] & ~bad_b;
    m.bwd_b  = cmd[BWD_B_BIT] & ~bad_b;
    m.duty_a = bad_a ? '0 : cmd[DUTY_A_HI:DUTY_A_LO];
    m.duty_b = bad_b ? '0 : cmd[DUTY_B_HI:DUTY_B_LO];
    m.fault  = bad_a | bad_b;
    return m;
  endfunction

endpackage

// File: rtl/drive_arbiter_if.sv
// Requester/command bundle and motor-side outputs of the drive arbiter.
interface drive_arbiter_if;
  import drive_pkg::*;

  logic              enable;
  logic [NREQ-1:0]   req;
  logic [CMD_W-1:0]  cmd0;
  logic [CMD_W-1:0]  cmd1;
  logic [CMD_W-1:0]  cmd2;

  logic              FWD_A;
  logic              FWD_B;
  logic              BWD_A;
  logic              BWD_B;
  logic [DUTY_W-1:0] Duty_SelA;
  logic [DUTY_W-1:0] Duty_SelB;
  logic [NREQ-1:0]   grant;
  logic              busy;
  logic              fault;

  modport master (
    output enable, req, cmd0, cmd1, cmd2,
    input  FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA, Duty_SelB, grant, busy, fault
  );

  modport slave (
    input  enable, req, cmd0, cmd1, cmd2,
    output FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA, Duty_SelB, grant, busy, fault
  );
endinterface

// File: rtl/drive_prio_enc.sv
// Fixed-priority encoder: lowest set request index wins, reported one-hot.
module drive_prio_enc
  import drive_pkg::*;
(
  input  logic [NREQ-1:0] req,
  output logic [NREQ-1:0] winner_c,
  output logic            valid_c
);

  always_comb begin
    winner_c = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (req[i] && (winner_c == '0)) winner_c[i] = 1'b1;
    end
  end

  assign valid_c = |req;

endmodule

// File: rtl/drive_arbiter.sv
// Arbitrates three drive requesters onto one H-bridge, inserting an all-off
// dead-time before every grant and holding grants against lower-urgency preemption.
module drive_arbiter
  import drive_pkg::*;
#(
  parameter int unsigned DEAD_CYCLES = 50_000,
  parameter int unsigned MIN_HOLD    = 5_000_000
) (
  input  logic            clk,
  input  logic            rst,
  drive_arbiter_if.slave  bus
);

  localparam int unsigned CNT_MAX = (DEAD_CYCLES > MIN_HOLD) ? DEAD_CYCLES : MIN_HOLD;
  localparam int unsigned CNT_W   = $clog2(CNT_MAX + 1);
  localparam logic [CNT_W-1:0] DEAD_LAST = CNT_W'(DEAD_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_MAX  = CNT_W'(MIN_HOLD);

  state_t          state_q, state_d;
  logic [NREQ-1:0] pending_q, pending_d;
  logic [NREQ-1:0] grant_q, grant_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  motor_t          motor_q, motor_d;
  logic            busy_q, busy_d;

  logic [NREQ-1:0] winner_c;
  logic            any_c;
  logic            granted_req_c;
  logic            emerg_c;
  logic            higher_c;
  logic [CMD_W-1:0] sel_cmd_c;

  drive_prio_enc u_prio (
    .req      (bus.req),
    .winner_c (winner_c),
    .valid_c  (any_c)
  );

  assign granted_req_c = |(bus.req & grant_q);
  assign emerg_c       = bus.req[0] & ~grant_q[0];
  assign higher_c      = granted_req_c & (winner_c != grant_q);

  // State, pending winner, owner and shared counter
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= IDLE;
      pending_q <= '0;
      grant_q   <= '0;
      cnt_q     <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= pending_d;
      grant_q   <= grant_d;
      cnt_q     <= cnt_d;
    end
  end

  // Next-state: every new owner passes through DEAD; enable low overrides everything
  always_comb begin
    state_d   = state_q;
    pending_d = pending_q;
    grant_d   = grant_q;
    cnt_d     = cnt_q;
    if (!bus.enable) begin
      state_d   = IDLE;
      pending_d = '0;
      grant_d   = '0;
      cnt_d     = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (any_c) begin
            state_d   = DEAD;
            pending_d = winner_c;
            cnt_d     = '0;
          end
        end
        DEAD: begin
          if (cnt_q == DEAD_LAST) begin
            cnt_d = '0;
            if (|(bus.req & pending_q)) begin
              state_d = ACTIVE;
              grant_d = pending_q;
            end else if (any_c) begin
              state_d   = DEAD;
              pending_d = winner_c;
            end else begin
              state_d   = IDLE;
              pending_d = '0;
            end
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        ACTIVE: begin
          if (!granted_req_c || emerg_c || (higher_c && (cnt_q == HOLD_MAX))) begin
            grant_d = '0;
            cnt_d   = '0;
            if (any_c) begin
              state_d   = DEAD;
              pending_d = winner_c;
            end else begin
              state_d   = IDLE;
              pending_d = '0;
            end
          end else if (cnt_q != HOLD_MAX) begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
        default: begin
          state_d   = IDLE;
          pending_d = '0;
          grant_d   = '0;
          cnt_d     = '0;
        end
      endcase
    end
  end

  // Output decode from the next state so motor outputs register alongside the grant
  always_comb begin
    sel_cmd_c = '0;
    motor_d   = '0;
    busy_d    = (state_d != IDLE);
    if (grant_d[0])      sel_cmd_c = bus.cmd0;
    else if (grant_d[1]) sel_cmd_c = bus.cmd1;
    else if (grant_d[2]) sel_cmd_c = bus.cmd2;
    if (state_d == ACTIVE) motor_d = cmd_filter(sel_cmd_c);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      motor_q <= '0;
      busy_q  <= 1'b0;
    end else begin
      motor_q <= motor_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.FWD_A     = motor_q.fwd_a;
  assign bus.FWD_B     = motor_q.fwd_b;
  assign bus.BWD_A     = motor_q.bwd_a;
  assign bus.BWD_B     = motor_q.bwd_b;
  assign bus.Duty_SelA = motor_q.duty_a;
  assign bus.Duty_SelB = motor_q.duty_b;
  assign bus.fault     = motor_q.fault;
  assign bus.grant     = grant_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_drive_arbiter.sv
// Directed bench for drive_arbiter with DEAD_CYCLES=4, MIN_HOLD=10; outputs sampled on negedge.
module tb_drive_arbiter;

  logic clk;
  logic rst;
  int   n_checks;
  int   n_pass;

  drive_arbiter_if bus();

  drive_arbiter #(.DEAD_CYCLES(4), .MIN_HOLD(10)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // {grant, FWD_A, FWD_B, BWD_A, BWD_B, Duty_SelA, Duty_SelB, busy, fault}
  function automatic logic [12:0] obs();
    return {bus.grant, bus.FWD_A, bus.FWD_B, bus.BWD_A, bus.BWD_B,
            bus.Duty_SelA, bus.Duty_SelB, bus.busy, bus.fault};
  endfunction

  function automatic logic [12:0] ev(input logic [2:0] g, input logic [7:0] m,
                                      input logic b, input logic f);
    return {g, m, b, f};
  endfunction

  task automatic check(input string tag, input logic [12:0] got, input logic [12:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
  endtask

  task automatic expect_cycles(input string tag, input int n, input logic [12:0] exp);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      check(tag, obs(), exp);
    end
  endtask

  logic [12:0] off;
  logic [12:0] zero;

  initial begin
    n_checks   = 0;
    n_pass     = 0;
    off        = ev(3'b000, 8'h00, 1'b1, 1'b0);
    zero       = ev(3'b000, 8'h00, 1'b0, 1'b0);
    rst        = 1'b1;
    bus.enable = 1'b0;
    bus.req    = 3'b000;
    bus.cmd0   = 8'h66;
    bus.cmd1   = 8'h95;
    bus.cmd2   = 8'hCA;
    repeat (2) @(negedge clk);
    check("reset", obs(), zero);

    // first grant after a full dead-time
    rst = 1'b0; bus.enable = 1'b1; bus.req = 3'b100;
    expect_cycles("first_dead", 4, off);
    expect_cycles("first_grant", 4, ev(3'b100, 8'hCA, 1'b1, 1'b0));

    // higher non-emergency request waits for hold count to saturate
    bus.req = 3'b110;
    expect_cycles("hold_keep", 7, ev(3'b100, 8'hCA, 1'b1, 1'b0));
    expect_cycles("hold_dead", 4, off);
    expect_cycles("hold_grant", 1, ev(3'b010, 8'h95, 1'b1, 1'b0));

    // emergency preempts immediately
    bus.req = 3'b111;
    expect_cycles("emerg_dead", 4, off);
    expect_cycles("emerg_grant", 1, ev(3'b001, 8'h66, 1'b1, 1'b0));

    // illegal commands and one-cycle command latency
    bus.cmd0 = 8'hAB;
    expect_cycles("illegal_a", 2, ev(3'b001, 8'h03, 1'b1, 1'b1));
    bus.cmd0 = 8'h5E;
    expect_cycles("illegal_b", 2, ev(3'b001, 8'h0C, 1'b1, 1'b1));
    bus.cmd0 = 8'hA0;
    expect_cycles("illegal_a0", 2, ev(3'b001, 8'h00, 1'b1, 1'b1));
    bus.cmd0 = 8'h33;
    expect_cycles("low_no_preempt", 15, ev(3'b001, 8'h33, 1'b1, 1'b0));

    // granted request drops: dead-time before the next owner
    bus.req = 3'b110;
    expect_cycles("drop_dead", 4, off);
    expect_cycles("drop_grant", 1, ev(3'b010, 8'h95, 1'b1, 1'b0));
    bus.req = 3'b100;
    expect_cycles("handoff_dead", 4, off);
    expect_cycles("handoff_grant", 1, ev(3'b100, 8'hCA, 1'b1, 1'b0));

    // emergency from owner 2
    bus.req = 3'b101;
    expect_cycles("emerg2_dead", 4, off);
    expect_cycles("emerg2_grant", 1, ev(3'b001, 8'h33, 1'b1, 1'b0));

    // enable low wins over held requests
    bus.enable = 1'b0;
    expect_cycles("enable_off", 3, zero);
    bus.enable = 1'b1;
    expect_cycles("enable_dead", 4, off);
    expect_cycles("enable_grant", 1, ev(3'b001, 8'h33, 1'b1, 1'b0));

    bus.req = 3'b000;
    expect_cycles("idle", 2, zero);

    // pending requester withdraws during dead-time: restart for new winner
    bus.req = 3'b100;
    expect_cycles("restart_a", 2, off);
    bus.req = 3'b010;
    expect_cycles("restart_b", 6, off);
    expect_cycles("restart_grant", 1, ev(3'b010, 8'h95, 1'b1, 1'b0));

    // reset mid-DEAD, then full dead-time after release
    bus.req = 3'b100;
    expect_cycles("pre_rst_dead", 2, off);
    rst = 1'b1;
    #1;
    check("rst_dead_async", obs(), zero);
    expect_cycles("rst_dead_held", 1, zero);
    rst = 1'b0;
    expect_cycles("post_rst_dead", 4, off);
    expect_cycles("post_rst_grant", 1, ev(3'b100, 8'hCA, 1'b1, 1'b0));

    // reset mid-ACTIVE clears outputs without waiting for a clock
    rst = 1'b1;
    #1;
    check("rst_active_async", obs(), zero);
    expect_cycles("rst_active_held", 1, zero);
    rst = 1'b0;
    bus.req = 3'b000;
    expect_cycles("final_idle", 2, zero);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
